writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter LQ_DEPTH, default 4, sets load-queue entries; power of two, range 2..16.
REQ-002 Parameter STARVE_MAX, default 4, sets the number of consecutive cycles a queued load may lose arbitration to ALU results.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 alu_valid  in  1 / alu_rd  in  5 / alu_data  in  32: ALU result offered this cycle.
REQ-006 alu_stall  out  1  ALU result not accepted this cycle; ALU holds its result.
REQ-007 load_valid  in  1 / load_rd  in  5 / load_data  in  32 / load_ready  out  1: load-result valid/ready handshake.
REQ-008 issue_valid  in  1 / issue_rd  in  5: decode marks a destination as pending.
REQ-009 rs1  in  5 / rs2  in  5 / rs1_busy  out  1 / rs2_busy  out  1: scoreboard query.
REQ-010 rd  out  5 / data  out  32 / reg_write  out  1: registered register-file write port; the register file samples on negedge.
REQ-011 rs1_fwd_valid, rs2_fwd_valid  out  1 / rs1_fwd_data, rs2_fwd_data  out  32: bypass outputs (see Configuration).

Function
REQ-012 Load transfer occurs when load_valid and load_ready are both 1 at posedge; the entry is pushed to the FIFO tail.
REQ-013 load_ready = not full; combinational from FIFO state only, never from load_valid.
REQ-014 Push and pop in the same cycle are both performed; count is unchanged.
REQ-015 Arbitration, each cycle: if starve_cnt == STARVE_MAX and FIFO non-empty, the FIFO head wins and alu_stall = alu_valid; else if alu_valid, ALU wins; else if FIFO non-empty, the head wins; else idle.
REQ-016 alu_stall is 1 only in the starvation case of REQ-015.
REQ-017 Winner is registered into rd/data at next posedge; reg_write = 1 iff winner exists and its rd != 0; latency exactly 1 cycle.
REQ-018 A winner with rd == 0 is consumed (popped/accepted) with reg_write = 0.
REQ-019 starve_cnt increments (saturating at STARVE_MAX) when the FIFO is non-empty and the ALU wins; clears when the FIFO head wins or the FIFO is empty.
REQ-020 Scoreboard busy[31:1]: set on issue_valid with issue_rd != 0; cleared when reg_write commits that rd (posedge on which reg_write goes 1); busy[0] constant 0.
REQ-021 Simultaneous set and clear of the same index: set wins.
REQ-022 rsN_busy = busy[rsN], combinational.
REQ-023 Full FIFO: further load_valid is held off; no data is lost or overwritten.
REQ-024 Pointers wrap modulo LQ_DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-025 On reset_n low: rd = 0, data = 0, reg_write = 0, FIFO empty (load_ready = 1), starve_cnt = 0, busy all 0, forward outputs 0.
REQ-026 Reset mid-operation discards queued loads and pending busy bits; the first post-release cycle behaves as idle.

Configuration
REQ-027 Macro WB_BYPASS_EN defined: rsN_fwd_valid = reg_write and rd == rsN and rsN != 0; rsN_fwd_data = data.
REQ-028 WB_BYPASS_EN undefined: rsN_fwd_valid and rsN_fwd_data tied to 0; no comparators synthesized.

Structure
REQ-029 Shared package holds the register-index width (5), the data width (32), and the writeback-entry typedef {rd, data}.
REQ-030 Load queue is a sub-module wb_fifo, parameterized on depth, exposing push/pop/full/empty/head.

Verification
REQ-031 Reset, then load_valid rd=5 data=0xAAAA5555 with ALU idle -> reg_write=1, rd=5, data=0xAAAA5555 two posedges after the push.
REQ-032 alu_valid every cycle plus one queued load, STARVE_MAX=4 -> 4 ALU writes, then alu_stall=1 for one cycle and the load is written; starve_cnt returns to 0.
REQ-033 Five loads pushed with no pops, LQ_DEPTH=4 -> load_ready=0 after the 4th push; the 5th is accepted only after the first pop; write order is preserved.
REQ-034 issue rd=7, then ALU write rd=7 -> rs1=7 reads busy 1 until the commit posedge, then 0; issue rd=7 in the same cycle as the commit -> busy stays 1.
REQ-035 ALU write with rd=0 data=0xFFFFFFFF -> reg_write=0 and busy[0] stays 0.
REQ-036 With WB_BYPASS_EN, a write of rd=3 data=0x12 with rs2=3 -> rs2_fwd_valid=1, rs2_fwd_data=0x12 while reg_write=1; without the macro both are 0.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared widths and the writeback entry carried from ALU/load queue to the register file.
package writeback_unit_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result queue: head is visible combinationally, push/pop take effect at posedge.
// Backpressure: caller must not push while full; extra pointer bit separates full from empty.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter (ALU vs queued loads) with destination scoreboard; 1-cycle registered write.
// Loads back-pressured by load_ready when queue full; ALU stalled only on load starvation. Bypass under WB_BYPASS_EN.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              load_valid,
  input  logic [REG_W-1:0]  load_rd,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] data,
  output logic              reg_write,
  output logic              rs1_fwd_valid,
  output logic              rs2_fwd_valid,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic [DATA_W-1:0] rs2_fwd_data
);

  localparam int              SC_W   = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);
  localparam logic [SC_W-1:0] SC_ONE = 1;

  logic      fifo_full;
  logic      fifo_empty;
  wb_entry_t fifo_head;
  wb_entry_t load_entry;
  logic      push;
  logic      starved;
  logic      load_win;
  logic      alu_win;
  logic      win_valid;
  wb_entry_t win;

  logic [SC_W-1:0] starve_cnt;
  logic [31:0]     busy;
  logic [31:0]     set_vec;
  logic [31:0]     clr_vec;

  assign load_ready = !fifo_full;
  assign push       = load_valid && load_ready;
  assign load_entry = '{rd: load_rd, data: load_data};

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (load_entry),
    .pop        (load_win),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // A starved head pre-empts the ALU for one slot; otherwise ALU has priority.
  assign starved   = (starve_cnt == SC_MAX) && !fifo_empty;
  assign load_win  = starved || (!alu_valid && !fifo_empty);
  assign alu_win   = alu_valid && !starved;
  assign alu_stall = starved && alu_valid;
  assign win_valid = load_win || alu_win;
  assign win       = load_win ? fifo_head : '{rd: alu_rd, data: alu_data};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd         <= '0;
      data       <= '0;
      reg_write  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      reg_write <= win_valid && (win.rd != '0);
      if (win_valid) begin
        rd   <= win.rd;
        data <= win.data;
      end
      if (fifo_empty || load_win)
        starve_cnt <= '0;
      else if (alu_win && starve_cnt != SC_MAX)
        starve_cnt <= starve_cnt + SC_ONE;
    end
  end

  // Clear lands on the same edge reg_write rises; a same-edge issue re-marks the register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid) set_vec[issue_rd] = 1'b1;
    if (win_valid)   clr_vec[win.rd]   = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= ((busy & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

`ifdef WB_BYPASS_EN
  assign rs1_fwd_valid = reg_write && (rd == rs1) && (rs1 != '0);
  assign rs2_fwd_valid = reg_write && (rd == rs2) && (rs2 != '0);
  assign rs1_fwd_data  = data;
  assign rs2_fwd_data  = data;
`else
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: latency, starvation, queue full, scoreboard, rd=0, bypass, reset.
module tb_writeback_unit;

  logic        clk;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        load_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rd;
  logic [31:0] data;
  logic        reg_write;
  logic        rs1_fwd_valid;
  logic        rs2_fwd_valid;
  logic [31:0] rs1_fwd_data;
  logic [31:0] rs2_fwd_data;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  writeback_unit #(.LQ_DEPTH(4), .STARVE_MAX(4)) dut (
    .clock         (clk),
    .reset_n       (reset_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_stall     (alu_stall),
    .load_valid    (load_valid),
    .load_rd       (load_rd),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rd            (rd),
    .data          (data),
    .reg_write     (reg_write),
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_data  (rs2_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] exp_rd, input logic [31:0] exp_data);
    check({tag, "_we"},   32'(reg_write), 32'd1);
    check({tag, "_rd"},   32'(rd),        32'(exp_rd));
    check({tag, "_data"}, data,           exp_data);
  endtask

  initial begin
    reset_n     = 1'b0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    load_valid  = 1'b0;
    load_rd     = '0;
    load_data   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = 5'd7;
    rs2         = 5'd3;
    repeat (3) tick;

    // Reset state
    check("rst_we",       32'(reg_write),     32'd0);
    check("rst_rd",       32'(rd),            32'd0);
    check("rst_data",     data,               32'd0);
    check("rst_ready",    32'(load_ready),    32'd1);
    check("rst_busy1",    32'(rs1_busy),      32'd0);
    check("rst_fwdv2",    32'(rs2_fwd_valid), 32'd0);
    check("rst_fwdd2",    rs2_fwd_data,       32'd0);
    reset_n = 1'b1;
    tick;
    check("idle_we", 32'(reg_write), 32'd0);

    // Single load, ALU idle: written on second posedge after being offered
    load_valid = 1'b1; load_rd = 5'd5; load_data = 32'hAAAA5555;
    tick;
    load_valid = 1'b0;
    check("ld1_push_we", 32'(reg_write), 32'd0);
    tick;
    check_wr("ld1", 5'd5, 32'hAAAA5555);
    tick;
    check("ld1_after_we", 32'(reg_write), 32'd0);

    // Starvation: continuous ALU traffic, one queued load
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1000;
    load_valid = 1'b1; load_rd = 5'd9; load_data = 32'h99;
    #1 check("stv_stall0", 32'(alu_stall), 32'd0);
    tick;
    load_valid = 1'b0;
    check_wr("stv_alu0", 5'd10, 32'h1000);
    for (int i = 1; i <= 4; i++) begin
      alu_data = 32'h1000 + i;
      #1 check("stv_stall_n", 32'(alu_stall), 32'd0);
      tick;
      check_wr("stv_alu_n", 5'd10, 32'h1000 + i);
    end
    alu_data = 32'h2000;
    #1 check("stv_stall1", 32'(alu_stall), 32'd1);
    tick;
    check_wr("stv_load", 5'd9, 32'h99);
    #1 check("stv_stall_clr", 32'(alu_stall), 32'd0);
    tick;
    check_wr("stv_held", 5'd10, 32'h2000);
    alu_valid = 1'b0;
    tick;

    // Queue full: ALU busy so no pops until starvation kicks in
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h3000;
    for (int i = 1; i <= 4; i++) begin
      load_valid = 1'b1; load_rd = 5'(10 + i); load_data = 32'h5000 + i;
      tick;
    end
    load_rd = 5'd15; load_data = 32'h5005;
    #1 check("full_ready0", 32'(load_ready), 32'd0);
    tick;
    check("full_hold", 32'(load_ready), 32'd0);
    check("full_stall", 32'(alu_stall), 32'd1);
    tick;
    check_wr("full_pop1", 5'd11, 32'h5001);
    check("full_ready1", 32'(load_ready), 32'd1);
    alu_valid = 1'b0;
    tick;
    load_valid = 1'b0;
    check_wr("full_pop2", 5'd12, 32'h5002);
    tick;
    check_wr("full_pop3", 5'd13, 32'h5003);
    tick;
    check_wr("full_pop4", 5'd14, 32'h5004);
    tick;
    check_wr("full_pop5", 5'd15, 32'h5005);
    tick;
    check("full_drained", 32'(reg_write), 32'd0);

    // Scoreboard set/clear, and set winning over a same-edge clear
    rs1 = 5'd7; rs2 = 5'd8;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick;
    issue_valid = 1'b0;
    check("sb_set", 32'(rs1_busy), 32'd1);
    check("sb_other", 32'(rs2_busy), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1 check("sb_precommit", 32'(rs1_busy), 32'd1);
    tick;
    alu_valid = 1'b0;
    check_wr("sb_commit", 5'd7, 32'h77);
    check("sb_cleared", 32'(rs1_busy), 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick;
    alu_valid = 1'b1;
    tick;
    issue_valid = 1'b0; alu_valid = 1'b0;
    check_wr("sb_same", 5'd7, 32'h77);
    check("sb_set_wins", 32'(rs1_busy), 32'd1);

    // rd = 0 is consumed without a write; busy[0] never sets
    rs2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick;
    alu_valid = 1'b0; issue_valid = 1'b0;
    check("r0_we", 32'(reg_write), 32'd0);
    check("r0_busy", 32'(rs2_busy), 32'd0);
    check("r0_fwd", 32'(rs2_fwd_valid), 32'd0);

    // Bypass outputs
    rs1 = 5'd4; rs2 = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h12;
    tick;
    alu_valid = 1'b0;
    check_wr("byp", 5'd3, 32'h12);
    check("byp_v2", 32'(rs2_fwd_valid), 32'(BYP));
    check("byp_d2", rs2_fwd_data, BYP ? 32'h12 : 32'h0);
    check("byp_v1", 32'(rs1_fwd_valid), 32'd0);
    tick;
    check("byp_v2_idle", 32'(rs2_fwd_valid), 32'd0);

    // Reset mid-operation discards queued load and busy bits
    rs1 = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h4000;
    load_valid = 1'b1; load_rd = 5'd20; load_data = 32'h4444;
    tick;
    alu_valid = 1'b0; load_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    check("mid_rst_we", 32'(reg_write), 32'd0);
    check("mid_rst_busy", 32'(rs1_busy), 32'd0);
    check("mid_rst_ready", 32'(load_ready), 32'd1);
    check("mid_rst_data", data, 32'd0);
    tick;
    reset_n = 1'b1;
    tick;
    check("post_rst_idle", 32'(reg_write), 32'd0);
    tick;
    check("post_rst_idle2", 32'(reg_write), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
